// File: rtl/retire_unit_if.sv
// rtl/retire_unit_if.sv - ROB head, completion and retire bundle for retire_unit
interface retire_unit_if #(
   parameter int DATA_WIDTH = 11,
   parameter int PUSH_WIDTH = 3,
   parameter int ELEMENTS   = 15
);
   localparam int IW = $clog2(ELEMENTS + 1);
   localparam int CW = $clog2(PUSH_WIDTH) + 1;

   logic [DATA_WIDTH*PUSH_WIDTH-1:0] head_data;
   logic [CW-1:0]                    head_valid_ct;
   logic [IW-1:0]                    head_idx;
   logic [CW-1:0]                    head_ready_ct;
   logic [IW*PUSH_WIDTH-1:0]         cmplt_tags;
   logic [CW-1:0]                    cmplt_valid_ct;
   logic [CW-1:0]                    cmplt_ready_ct;
   logic                             hold;
   logic [DATA_WIDTH*PUSH_WIDTH-1:0] retire_data;
   logic [CW-1:0]                    retire_valid_ct;
   logic [15:0]                      retire_count;

   modport master (
      output head_data, head_valid_ct, head_idx, cmplt_tags, cmplt_valid_ct, hold,
      input  head_ready_ct, cmplt_ready_ct, retire_data, retire_valid_ct, retire_count
   );

   modport slave (
      input  head_data, head_valid_ct, head_idx, cmplt_tags, cmplt_valid_ct, hold,
      output head_ready_ct, cmplt_ready_ct, retire_data, retire_valid_ct, retire_count
   );
endinterface

// File: rtl/retire_unit.sv
// rtl/retire_unit.sv - in-order retirement of completed ROB head entries
module retire_unit #(
   parameter int DATA_WIDTH = 11,
   parameter int PUSH_WIDTH = 3,
   parameter int ELEMENTS   = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   retire_unit_if.slave bus
);
   localparam int SLOTS = ELEMENTS + 1;
   localparam int IW    = $clog2(ELEMENTS + 1);
   localparam int CW    = $clog2(PUSH_WIDTH) + 1;

   logic [SLOTS-1:0]                 done;
   logic [SLOTS-1:0]                 done_nxt;
   logic [IW-1:0]                    slot [PUSH_WIDTH];
   logic [PUSH_WIDTH-1:0]            serial;
   logic [CW-1:0]                    head_lim;
   logic [CW-1:0]                    cmplt_lim;
   logic [CW-1:0]                    n;
   logic [DATA_WIDTH*PUSH_WIDTH-1:0] retire_nxt;
   logic [DATA_WIDTH*PUSH_WIDTH-1:0] retire_data_q;
   logic [CW-1:0]                    retire_valid_q;
   logic [15:0]                      retire_count_q;

   assign head_lim  = (int'(bus.head_valid_ct) > PUSH_WIDTH) ? CW'(PUSH_WIDTH) : bus.head_valid_ct;
   assign cmplt_lim = (int'(bus.cmplt_valid_ct) > PUSH_WIDTH) ? CW'(PUSH_WIDTH) : bus.cmplt_valid_ct;

   always_comb begin
      logic [IW:0] sum;
      sum = '0;
      for (int k = 0; k < PUSH_WIDTH; k++) begin
         sum = {1'b0, bus.head_idx} + (IW+1)'(k);
         if (sum >= (IW+1)'(SLOTS))
            sum = sum - (IW+1)'(SLOTS);
         slot[k]   = sum[IW-1:0];
         serial[k] = bus.head_data[k*DATA_WIDTH + DATA_WIDTH-1];
      end
   end

   // A serializing entry always retires alone: it blocks younger lanes and
   // cannot join older ones.
   always_comb begin
      logic run;
      run = rst_n && !bus.hold;
      n   = '0;
      for (int k = 0; k < PUSH_WIDTH; k++) begin
         if (run && k < int'(head_lim) && done[slot[k]] &&
             (k == 0 || (!serial[k] && !serial[0])))
            n = CW'(k + 1);
         else
            run = 1'b0;
      end
   end

   // Clear is applied after set so a stale report for a leaving entry is dropped.
   always_comb begin
      done_nxt   = done;
      retire_nxt = '0;
      for (int i = 0; i < PUSH_WIDTH; i++)
         if (i < int'(cmplt_lim) && int'(bus.cmplt_tags[i*IW +: IW]) <= ELEMENTS)
            done_nxt[bus.cmplt_tags[i*IW +: IW]] = 1'b1;
      for (int k = 0; k < PUSH_WIDTH; k++)
         if (k < int'(n)) begin
            done_nxt[slot[k]] = 1'b0;
            retire_nxt[k*DATA_WIDTH +: DATA_WIDTH] = bus.head_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done           <= '0;
         retire_data_q  <= '0;
         retire_valid_q <= '0;
         retire_count_q <= '0;
      end else begin
         done           <= done_nxt;
         retire_data_q  <= retire_nxt;
         retire_valid_q <= n;
         retire_count_q <= retire_count_q + 16'(n);
      end
   end

   assign bus.head_ready_ct   = n;
   assign bus.cmplt_ready_ct  = CW'(PUSH_WIDTH);
   assign bus.retire_data     = retire_data_q;
   assign bus.retire_valid_ct = retire_valid_q;
   assign bus.retire_count    = retire_count_q;
endmodule

// File: tb/tb_retire_unit.sv
// tb/tb_retire_unit.sv - directed scoreboard bench for retire_unit
module tb_retire_unit;
   localparam int DW = 11;
   localparam int PW = 3;
   localparam int EL = 15;
   localparam int IW = $clog2(EL + 1);
   localparam int CW = $clog2(PW) + 1;

   typedef struct {
      logic [CW-1:0]    vc;
      logic [DW*PW-1:0] data;
      logic [15:0]      cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] exp_cnt = '0;
   exp_t sb [$];

   retire_unit_if #(.DATA_WIDTH(DW), .PUSH_WIDTH(PW), .ELEMENTS(EL)) bus ();

   retire_unit #(.DATA_WIDTH(DW), .PUSH_WIDTH(PW), .ELEMENTS(EL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive, check head_ready_ct, push expectation, clock, pop and compare.
   task automatic step(input string name, input logic [IW*PW-1:0] tags, input logic [CW-1:0] cv,
                       input logic [IW-1:0] hi, input logic [CW-1:0] hv,
                       input logic [PW-1:0] ser, input logic hd, input int exp_n);
      logic [DW*PW-1:0] d;
      exp_t e, got;
      d = '0;
      for (int k = 0; k < PW; k++) begin
         d[k*DW +: DW] = DW'($urandom);
         d[k*DW + DW-1] = ser[k];
      end
      bus.cmplt_tags     = tags;
      bus.cmplt_valid_ct = cv;
      bus.head_idx       = hi;
      bus.head_valid_ct  = hv;
      bus.head_data      = d;
      bus.hold           = hd;
      #1;
      check({name, ".ready"}, 64'(bus.head_ready_ct), 64'(exp_n));
      e.vc   = CW'(exp_n);
      e.data = '0;
      for (int k = 0; k < PW; k++)
         if (k < exp_n) e.data[k*DW +: DW] = d[k*DW +: DW];
      exp_cnt = exp_cnt + 16'(exp_n);
      e.cnt  = exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({name, ".sb_empty"}, 64'(1), 64'(0));
      end else begin
         got = sb.pop_front();
         check({name, ".retire_valid_ct"}, 64'(bus.retire_valid_ct), 64'(got.vc));
         check({name, ".retire_data"}, 64'(bus.retire_data), 64'(got.data));
         check({name, ".retire_count"}, 64'(bus.retire_count), 64'(got.cnt));
      end
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.head_data      = '0;
      bus.head_valid_ct  = '0;
      bus.head_idx       = '0;
      bus.cmplt_tags     = '0;
      bus.cmplt_valid_ct = '0;
      bus.hold           = 1'b0;
      #3;
      check("rst.retire_valid_ct", 64'(bus.retire_valid_ct), 64'(0));
      check("rst.retire_count", 64'(bus.retire_count), 64'(0));
      check("rst.head_ready_ct", 64'(bus.head_ready_ct), 64'(0));
      check("rst.retire_data", 64'(bus.retire_data), 64'(0));
      check("cmplt_ready_ct", 64'(bus.cmplt_ready_ct), 64'(PW));
      @(negedge clk);
      rst_n = 1'b1;

      step("lat_t0",  {4'd4, 4'd3, 4'd2}, 3'd3, 4'd2, 3'd3, 3'b000, 1'b0, 0);
      step("lat_t1",  '0,                 3'd0, 4'd2, 3'd3, 3'b000, 1'b0, 3);
      step("gap_set", {4'd0, 4'd7, 4'd5}, 3'd2, 4'd5, 3'd3, 3'b000, 1'b0, 0);
      step("gap_one", {4'd0, 4'd0, 4'd6}, 3'd1, 4'd5, 3'd3, 3'b000, 1'b0, 1);
      step("gap_two", '0,                 3'd0, 4'd6, 3'd3, 3'b000, 1'b0, 2);
      step("wrap_set",{4'd0, 4'd15,4'd14},3'd3, 4'd8, 3'd0, 3'b000, 1'b0, 0);
      step("wrap_ret",'0,                 3'd0, 4'd14,3'd7, 3'b000, 1'b0, 3);
      step("wrap_c14",'0,                 3'd0, 4'd14,3'd1, 3'b000, 1'b0, 0);
      step("wrap_c15",'0,                 3'd0, 4'd15,3'd1, 3'b000, 1'b0, 0);
      step("wrap_c0", '0,                 3'd0, 4'd0, 3'd1, 3'b000, 1'b0, 0);
      step("ser_set", {4'd3, 4'd2, 4'd1}, 3'd3, 4'd8, 3'd0, 3'b000, 1'b0, 0);
      step("ser_l1",  '0,                 3'd0, 4'd1, 3'd3, 3'b010, 1'b0, 1);
      step("ser_l0",  '0,                 3'd0, 4'd2, 3'd3, 3'b001, 1'b0, 1);
      step("ser_next",'0,                 3'd0, 4'd3, 3'd1, 3'b000, 1'b0, 1);
      step("hold_set",{4'd11,4'd10,4'd9}, 3'd3, 4'd8, 3'd0, 3'b000, 1'b0, 0);
      step("hold_a",  '0,                 3'd0, 4'd9, 3'd3, 3'b000, 1'b1, 0);
      step("hold_b",  '0,                 3'd0, 4'd9, 3'd3, 3'b000, 1'b1, 0);
      step("hold_rel",'0,                 3'd0, 4'd9, 3'd3, 3'b000, 1'b0, 3);
      step("dup_set", {4'd12,4'd12,4'd12},3'd3, 4'd8, 3'd0, 3'b000, 1'b0, 0);
      step("dup_ret", {4'd13,4'd13,4'd13},3'd7, 4'd12,3'd1, 3'b000, 1'b0, 1);
      step("cv_clamp",{4'd0, 4'd0, 4'd5}, 3'd1, 4'd13,3'd1, 3'b000, 1'b0, 1);

      bus.cmplt_valid_ct = '0;
      bus.head_idx       = 4'd5;
      bus.head_valid_ct  = 3'd1;
      bus.head_data      = '0;
      #1;
      check("pre_rst.ready", 64'(bus.head_ready_ct), 64'(1));
      check("pre_rst.retire_count", 64'(bus.retire_count), 64'(17));
      rst_n = 1'b0;
      #1;
      check("mid_rst.head_ready_ct", 64'(bus.head_ready_ct), 64'(0));
      check("mid_rst.retire_valid_ct", 64'(bus.retire_valid_ct), 64'(0));
      check("mid_rst.retire_count", 64'(bus.retire_count), 64'(0));
      exp_cnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst",'0,                 3'd0, 4'd5, 3'd1, 3'b000, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
